// File: rtl/multiplier_seq_32bits_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package multiplier_seq_32bits_pkg;

  localparam int MUL_ITER  = 32;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/adder_32bits.sv
// 32-bit carry-select adder built from four 8-bit blocks.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  localparam int BLK   = 8;
  localparam int N_BLK = 32 / BLK;

  logic [N_BLK:0] carry;

  assign carry[0] = ci;

  generate
    for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
      logic [BLK:0] sum0;
      logic [BLK:0] sum1;

      // Both carry-in cases precomputed; the incoming carry only selects.
      assign sum0 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]};
      assign sum1 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};

      assign s[gi*BLK +: BLK] = carry[gi] ? sum1[BLK-1:0] : sum0[BLK-1:0];
      assign carry[gi+1]      = carry[gi] ? sum1[BLK]     : sum0[BLK];
    end
  endgenerate

  assign co = carry[N_BLK];

endmodule

// File: rtl/mux_2to1.sv
// Generic two-input multiplexer.
module mux_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/multiplier_seq_32bits.sv
// Unsigned 32x32->64 shift-and-add multiplier; one iteration per cycle
// through a single shared adder, start/busy/done handshake.
module multiplier_seq_32bits
  import multiplier_seq_32bits_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_t           state_reg,   state_next;
  logic [31:0]          mcand_reg,   mcand_next;
  logic [31:0]          acc_hi_reg,  acc_hi_next;
  logic [31:0]          acc_lo_reg,  acc_lo_next;
  logic [MUL_CNT_W-1:0] cnt_reg,     cnt_next;
  logic [63:0]          product_reg, product_next;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        carry_out;
  logic [63:0] shifted;

  mux_2to1 #(.WIDTH(32)) u_gate (
    .sel (acc_lo_reg[0]),
    .d0  (32'd0),
    .d1  (mcand_reg),
    .y   (addend)
  );

  adder_32bits u_adder (
    .a  (acc_hi_reg),
    .b  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (carry_out)
  );

  // 65-bit right shift: the adder carry becomes the new accumulator MSB.
  assign shifted = {carry_out, sum, acc_lo_reg[31:1]};

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    acc_hi_next  = acc_hi_reg;
    acc_lo_next  = acc_lo_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    unique case (state_reg)
      MUL_IDLE: begin
        if (start) begin
          mcand_next  = a;
          acc_hi_next = '0;
          acc_lo_next = b;
          cnt_next    = '0;
          state_next  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        acc_hi_next = shifted[63:32];
        acc_lo_next = shifted[31:0];
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == MUL_CNT_W'(MUL_ITER - 1)) begin
          product_next = shifted;
          state_next   = MUL_DONE;
        end
      end
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MUL_IDLE;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      acc_hi_reg  <= acc_hi_next;
      acc_lo_reg  <= acc_lo_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  assign busy    = (state_reg == MUL_RUN);
  assign done    = (state_reg == MUL_DONE);
  assign product = product_reg;

endmodule
